// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: tracks in-flight destinations and drives stall / forwarding selects.
// Outputs are combinational against registered entries; freeze holds all state, reset clears it.
module hazard_scoreboard #(
  parameter int NUM_REGS = 8,
  parameter int DEPTH    = 3,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16,
  localparam int REG_W   = $clog2(NUM_REGS),
  localparam int SELW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_rs_valid,
  input  logic                id_rt_valid,
  input  logic [REG_W-1:0]    id_wr_reg,
  input  logic                id_wr_valid,
  input  logic                id_is_load,
  input  logic                freeze,
  input  logic                flush,
  output logic                stall,
  output logic [SELW-1:0]     fwd_rs_sel,
  output logic [SELW-1:0]     fwd_rt_sel,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [CNT_W-1:0]    stall_count
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [REG_W-1:0] dst_q [DEPTH];
  logic [REG_W-1:0] dst_d [DEPTH];
  // Only the EX entry needs the load flag: from MEM onward load data is forwardable.
  logic             ld0_q, ld0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DEPTH-2:0] m_rs, m_rt;
  logic             stall_raw;
  logic             accept;

  always_comb begin
    m_rs = '0;
    m_rt = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      m_rs[k] = id_rs_valid && v_q[k] && (dst_q[k] == id_rs);
      m_rt[k] = id_rt_valid && v_q[k] && (dst_q[k] == id_rt);
    end
  end

  always_comb begin
    if (FWD_EN != 0) stall_raw = ld0_q && (m_rs[0] || m_rt[0]);
    else             stall_raw = (|m_rs) || (|m_rt);
  end

  assign stall = id_valid && stall_raw;

  // Scan oldest-to-youngest so the youngest match overwrites; a load in EX is skipped.
  always_comb begin
    fwd_rs_sel = '0;
    fwd_rt_sel = '0;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      if (m_rs[k] && !(k == 0 && ld0_q)) fwd_rs_sel = SELW'(k + 1);
      if (m_rt[k] && !(k == 0 && ld0_q)) fwd_rt_sel = SELW'(k + 1);
    end
    if (FWD_EN == 0 || !id_valid) begin
      fwd_rs_sel = '0;
      fwd_rt_sel = '0;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (v_q[k]) busy_mask[dst_q[k]] = 1'b1;
    end
  end

  assign accept = id_valid && !stall && !flush;

  always_comb begin
    v_d   = v_q;
    dst_d = dst_q;
    ld0_d = ld0_q;
    cnt_d = cnt_q;
    if (!freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        v_d[k]   = v_q[k-1];
        dst_d[k] = dst_q[k-1];
      end
      v_d[0]   = accept && id_wr_valid;
      dst_d[0] = id_wr_reg;
      ld0_d    = id_is_load;
      if (stall && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q   <= '0;
      ld0_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      ld0_q <= ld0_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    dst_q <= dst_d;
  end

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (forwarding, no forwarding, 2-bit counter) on shared stimulus.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0, id_rs_valid = 1'b0, id_rt_valid = 1'b0;
  logic [2:0] id_rs = '0, id_rt = '0, id_wr_reg = '0;
  logic       id_wr_valid = 1'b0, id_is_load = 1'b0, freeze = 1'b0, flush = 1'b0;

  always #5 clk = ~clk;

  logic       st_a, st_b, st_c;
  logic [2:0] rs_a, rt_a, rs_b, rt_b, rs_c, rt_c;
  logic [7:0] busy_a, busy_b, busy_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  hazard_scoreboard #(.NUM_REGS(8), .DEPTH(3), .FWD_EN(1), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_wr_reg(id_wr_reg),
    .id_wr_valid(id_wr_valid), .id_is_load(id_is_load), .freeze(freeze), .flush(flush),
    .stall(st_a), .fwd_rs_sel(rs_a), .fwd_rt_sel(rt_a), .busy_mask(busy_a), .stall_count(cnt_a));

  hazard_scoreboard #(.NUM_REGS(8), .DEPTH(3), .FWD_EN(0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_wr_reg(id_wr_reg),
    .id_wr_valid(id_wr_valid), .id_is_load(id_is_load), .freeze(freeze), .flush(flush),
    .stall(st_b), .fwd_rs_sel(rs_b), .fwd_rt_sel(rt_b), .busy_mask(busy_b), .stall_count(cnt_b));

  hazard_scoreboard #(.NUM_REGS(8), .DEPTH(3), .FWD_EN(1), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_valid(id_rs_valid), .id_rt_valid(id_rt_valid), .id_wr_reg(id_wr_reg),
    .id_wr_valid(id_wr_valid), .id_is_load(id_is_load), .freeze(freeze), .flush(flush),
    .stall(st_c), .fwd_rs_sel(rs_c), .fwd_rt_sel(rt_c), .busy_mask(busy_c), .stall_count(cnt_c));

  // Observation vector: {stall, rs_sel, rt_sel, busy_mask, stall_count}
  logic [30:0] obs_a, obs_b, obs_c;
  assign obs_a = {st_a, rs_a, rt_a, busy_a, cnt_a};
  assign obs_b = {st_b, rs_b, rt_b, busy_b, cnt_b};
  assign obs_c = {st_c, rs_c, rt_c, busy_c, 14'd0, cnt_c};

  typedef struct {
    logic [30:0] val;
    logic [30:0] mask;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  localparam logic [30:0] M_ALL = 31'h7FFF_FFFF;
  localparam logic [30:0] M_DC  = 31'h40FF_FFFF;  // selects ignored while stalling

  task automatic drive(input logic v, input logic [2:0] rs, input logic rsv,
                       input logic [2:0] rt, input logic rtv, input logic [2:0] wr,
                       input logic wrv, input logic ld, input logic frz, input logic fl);
    id_valid = v;  id_rs = rs; id_rs_valid = rsv; id_rt = rt; id_rt_valid = rtv;
    id_wr_reg = wr; id_wr_valid = wrv; id_is_load = ld; freeze = frz; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic expect_out(input string nm, input logic s, input logic [2:0] ers,
                            input logic [2:0] ert, input logic [7:0] eb,
                            input logic [15:0] ec, input logic dc);
    exp_t e;
    e.val  = {s, ers, ert, eb, ec};
    e.mask = dc ? M_DC : M_ALL;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [30:0] o [3];
    rst = 1'b0;
    drive(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 3; j++) expect_out("reset_state", 0, 0, 0, 8'h00, 16'd0, 0);
      @(negedge clk);
      o[0] = obs_a; o[1] = obs_b; o[2] = obs_c;
      for (int j = 0; j < 3; j++) begin
        e = sb.pop_front();
        total++;
        if ((o[j] & e.mask) !== (e.val & e.mask))
          $display("FAIL %s inst%0d cyc%0d: got %h want %h", e.name, j, i, o[j], e.val);
        else passed++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drive(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0); expect_out("b2b_add", 0, 0, 0, 8'h00, 0, 0); end
        1: begin drive(1, 3'd3, 1, 3'd1, 1, 3'd4, 1, 0, 0, 0); expect_out("b2b_fwd_ex", 0, 1, 0, 8'h08, 0, 0); end
        2: begin drive(0, 3'd3, 1, 3'd3, 1, 3'd0, 0, 0, 0, 0); expect_out("nop_unqualified", 0, 0, 0, 8'h18, 0, 0); end
        3: begin drive(1, 3'd4, 1, 3'd3, 1, 3'd0, 0, 0, 0, 0); expect_out("gap_fwd_mem", 0, 2, 0, 8'h18, 0, 0); end
        default: begin drive(1, 3'd4, 1, 3'd0, 0, 3'd0, 0, 0, 0, 0); expect_out("wb_no_fwd", 0, 0, 0, 8'h10, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ((obs_a & e.mask) !== (e.val & e.mask))
        $display("FAIL %s: got %h want %h", e.name, obs_a & e.mask, e.val & e.mask);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0); expect_out("lu_load", 0, 0, 0, 8'h00, 0, 0); end
        1: begin drive(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0, 0, 0); expect_out("lu_stall", 1, 0, 0, 8'h04, 0, 1); end
        2: begin drive(1, 3'd1, 1, 3'd2, 1, 3'd5, 1, 0, 0, 0); expect_out("lu_fwd_mem", 0, 0, 2, 8'h04, 1, 0); end
        default: begin idle(); expect_out("lu_after", 0, 0, 0, 8'h24, 1, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ((obs_a & e.mask) !== (e.val & e.mask))
        $display("FAIL %s: got %h want %h", e.name, obs_a & e.mask, e.val & e.mask);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_no_forwarding();
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin drive(1, 3'd0, 1, 3'd0, 0, 3'd5, 1, 0, 0, 0); expect_out("nf_addi", 0, 0, 0, 8'h00, 0, 0); end
        1: begin drive(1, 3'd5, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0); expect_out("nf_stall1", 1, 0, 0, 8'h20, 0, 0); end
        2: begin drive(1, 3'd5, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0); expect_out("nf_stall2", 1, 0, 0, 8'h20, 1, 0); end
        3: begin drive(1, 3'd5, 1, 3'd0, 0, 3'd6, 1, 0, 0, 0); expect_out("nf_issue", 0, 0, 0, 8'h20, 2, 0); end
        default: begin idle(); expect_out("nf_after", 0, 0, 0, 8'h40, 2, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ((obs_b & e.mask) !== (e.val & e.mask))
        $display("FAIL %s: got %h want %h", e.name, obs_b & e.mask, e.val & e.mask);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_freeze_flush();
    exp_t e;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: begin drive(1, 3'd0, 0, 3'd0, 0, 3'd1, 1, 1, 0, 0); expect_out("ff_load", 0, 0, 0, 8'h00, 0, 0); end
        1, 3: begin drive(1, 3'd1, 1, 3'd0, 0, 3'd7, 1, 0, 1, 0); expect_out("ff_frozen", 1, 0, 0, 8'h02, 0, 1); end
        2: begin drive(1, 3'd1, 1, 3'd0, 0, 3'd7, 1, 0, 1, 1); expect_out("ff_frozen_flush", 1, 0, 0, 8'h02, 0, 1); end
        4: begin drive(1, 3'd1, 1, 3'd0, 0, 3'd7, 1, 0, 0, 0); expect_out("ff_released", 1, 0, 0, 8'h02, 0, 1); end
        5: begin drive(1, 3'd1, 1, 3'd0, 0, 3'd7, 1, 0, 0, 1); expect_out("ff_flush", 0, 2, 0, 8'h02, 1, 0); end
        6: begin idle(); expect_out("ff_flushed_gone", 0, 0, 0, 8'h02, 1, 0); end
        7: begin drive(1, 3'd0, 0, 3'd0, 0, 3'd3, 1, 1, 0, 0); expect_out("ff_load2", 0, 0, 0, 8'h00, 1, 0); end
        8: begin drive(0, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 1, 1); rst = 1'b0;
                 expect_out("ff_pre_reset", 0, 0, 0, 8'h08, 1, 0); end
        default: begin idle(); rst = 1'b1; expect_out("ff_mid_reset", 0, 0, 0, 8'h00, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ((obs_a & e.mask) !== (e.val & e.mask))
        $display("FAIL %s: got %h want %h", e.name, obs_a & e.mask, e.val & e.mask);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    int   c0, c1;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      c0 = (p > 3) ? 3 : p;
      c1 = (p + 1 > 3) ? 3 : p + 1;
      for (int r = 0; r < 3; r++) begin
        case (r)
          0: begin drive(1, 3'd0, 0, 3'd0, 0, 3'd2, 1, 1, 0, 0);
                   expect_out("sat_load", 0, 0, 0, (p == 0) ? 8'h00 : 8'h04, 16'(c0), 0); end
          1: begin drive(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0);
                   expect_out("sat_stall", 1, 0, 0, 8'h04, 16'(c0), 1); end
          default: begin drive(1, 3'd0, 0, 3'd2, 1, 3'd0, 0, 0, 0, 0);
                   expect_out("sat_issue", 0, 0, 2, 8'h04, 16'(c1), 0); end
        endcase
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if ((obs_c & e.mask) !== (e.val & e.mask))
          $display("FAIL %s p%0d: got %h want %h", e.name, p, obs_c & e.mask, e.val & e.mask);
        else passed++;
        @(posedge clk); #1;
      end
    end
    total++;
    if (cnt_a !== 16'd5) $display("FAIL wide_count: got %0d want 5", cnt_a);
    else passed++;
  endtask

  task automatic test_youngest_wins();
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0, 0); expect_out("yw_w1", 0, 0, 0, 8'h00, 0, 0); end
        1: begin drive(1, 3'd0, 0, 3'd0, 0, 3'd4, 1, 0, 0, 0); expect_out("yw_w2", 0, 0, 0, 8'h10, 0, 0); end
        2: begin drive(1, 3'd4, 1, 3'd4, 1, 3'd0, 0, 0, 0, 0); expect_out("yw_youngest", 0, 1, 1, 8'h10, 0, 0); end
        default: begin idle(); expect_out("yw_after", 0, 0, 0, 8'h10, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if ((obs_c & e.mask) !== (e.val & e.mask))
        $display("FAIL %s: got %h want %h", e.name, obs_c & e.mask, e.val & e.mask);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_no_forwarding();
    test_freeze_flush();
    test_saturation();
    test_youngest_wins();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
